// File: rtl/dot_product_seq.sv
// Sequential dot-product engine: one W x W element product is accumulated per clock over N elements.
// Define DOT_PRODUCT_SAT_EN to make the accumulator saturate on overflow instead of wrapping.
module dot_product_seq #(
   parameter int N     = 6,
   parameter int W     = 1,
   parameter int ACC_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               acc_mode,
   input  logic [N*W-1:0]     a_in,
   input  logic [N*W-1:0]     b_in,
   output logic               busy,
   output logic               done,
   output logic [ACC_W-1:0]   result,
   output logic               ovf
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [N*W-1:0]      a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [ACC_W-1:0]    acc_q, acc_d, result_q, result_d;
   logic                of_q, of_d, ovf_q, ovf_d, done_q, done_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [2*W-1:0]      a_ext, b_ext, prod;
   logic [ACC_W:0]      prod_ext, sum;
   logic                carry;
   logic [ACC_W-1:0]    acc_next;

   always_comb begin
      a_ext    = {{W{1'b0}}, a_sh_q[W-1:0]};
      b_ext    = {{W{1'b0}}, b_sh_q[W-1:0]};
      prod     = a_ext * b_ext;
      prod_ext = '0;
      prod_ext[2*W-1:0] = prod;
      sum      = {1'b0, acc_q} + prod_ext;
      carry    = sum[ACC_W];
`ifdef DOT_PRODUCT_SAT_EN
      // once clamped, later adds of non-zero products carry again, so the clamp holds
      acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_next = sum[ACC_W-1:0];
`endif
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      acc_d    = acc_q;
      of_d     = of_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a_in;
               b_sh_d  = b_in;
               acc_d   = acc_mode ? result_q : '0;
               of_d    = acc_mode ? ovf_q : 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d  = acc_next;
            of_d   = of_q | carry;
            a_sh_d = a_sh_q >> W;
            b_sh_d = b_sh_q >> W;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               result_d = acc_next;
               ovf_d    = of_q | carry;
               done_d   = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         acc_q    <= '0;
         of_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         acc_q    <= acc_d;
         of_q     <= of_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign result = result_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed bench for dot_product_seq: three configurations, table-driven vectors plus hand sequences.
module tb_dot_product_seq;

`ifdef DOT_PRODUCT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // N=6, W=1, ACC_W=4
   logic rst_a, start_a, mode_a, busy_a, done_a, ovf_a;
   logic [5:0] a6, b6;
   logic [3:0] res_a;
   // B: N=4, W=4, ACC_W=12 ; C: N=4, W=4, ACC_W=8 (shared operand buses)
   logic [15:0] a16, b16;
   logic mode, rst_b, rst_c, start_b, start_c;
   logic busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
   logic [11:0] res_b;
   logic [7:0]  res_c;

   dot_product_seq #(.N(6), .W(1), .ACC_W(4)) u_a (
      .clock(clk), .reset(rst_a), .start(start_a), .acc_mode(mode_a),
      .a_in(a6), .b_in(b6), .busy(busy_a), .done(done_a), .result(res_a), .ovf(ovf_a));

   dot_product_seq #(.N(4), .W(4), .ACC_W(12)) u_b (
      .clock(clk), .reset(rst_b), .start(start_b), .acc_mode(mode),
      .a_in(a16), .b_in(b16), .busy(busy_b), .done(done_b), .result(res_b), .ovf(ovf_b));

   dot_product_seq #(.N(4), .W(4), .ACC_W(8)) u_c (
      .clock(clk), .reset(rst_c), .start(start_c), .acc_mode(mode),
      .a_in(a16), .b_in(b16), .busy(busy_c), .done(done_c), .result(res_c), .ovf(ovf_c));

   typedef struct {
      int          sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        m;
      logic [11:0] r;
      logic        o;
   } vec_t;

   vec_t tbl[10];
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Entered at a negedge (idle or done cycle); returns at the negedge where done is seen.
   task automatic run_vec(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic m, output int lat);
      a16 = a; b16 = b; mode = m;
      if (sel == 0) start_b = 1'b1; else start_c = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0; start_c = 1'b0;
      chk("busy_after_load", (sel == 0) ? busy_b : busy_c, 1);
      lat = 0;
      while (!((sel == 0) ? done_b : done_c) && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, busy_n, done_n, first;
      logic [11:0] r;
      logic o;

      tbl[0] = '{0, 16'h4321, 16'h8765, 1'b0, 12'd70,   1'b0};
      tbl[1] = '{0, 16'h4321, 16'h8765, 1'b1, 12'd140,  1'b0};
      tbl[2] = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 12'd900,  1'b0};
      tbl[3] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 12'd1800, 1'b0};
      tbl[4] = '{0, 16'h0001, 16'h0001, 1'b0, 12'd1,    1'b0};
      tbl[5] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, SAT ? 12'd255 : 12'd132, 1'b1};
      tbl[6] = '{1, 16'h0001, 16'h0001, 1'b0, 12'd1,    1'b0};
      tbl[7] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, SAT ? 12'd255 : 12'd133, 1'b1};
      tbl[8] = '{1, 16'h0000, 16'h0000, 1'b1, SAT ? 12'd255 : 12'd133, 1'b1};
      tbl[9] = '{1, 16'h4321, 16'h8765, 1'b0, 12'd70,   1'b0};

      rst_a = 1; rst_b = 1; rst_c = 1;
      start_a = 0; start_b = 0; start_c = 0; mode_a = 0; mode = 0;
      a6 = '0; b6 = '0; a16 = '0; b16 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy_a", busy_a, 0); chk("rst_done_a", done_a, 0);
      chk("rst_res_a", res_a, 0);   chk("rst_ovf_a", ovf_a, 0);
      chk("rst_busy_b", busy_b, 0); chk("rst_res_b", res_b, 0);
      chk("rst_busy_c", busy_c, 0); chk("rst_ovf_c", ovf_c, 0);
      rst_a = 0; rst_b = 0; rst_c = 0;
      @(negedge clk);

      // N=6 single-bit case: busy length, done position and pulse width
      a6 = 6'b101101; b6 = 6'b111001; start_a = 1;
      @(posedge clk);
      @(negedge clk);
      start_a = 0;
      busy_n = 0; done_n = 0; first = -1; r = '0; o = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (busy_a) busy_n++;
         if (done_a) begin
            done_n++;
            if (first < 0) begin first = i; r = {8'd0, res_a}; o = ovf_a; end
         end
         @(negedge clk);
      end
      chk("a_busy_cycles", busy_n, 6);
      chk("a_done_cycle", first, 6);
      chk("a_done_count", done_n, 1);
      chk("a_result", r, 3);
      chk("a_ovf", o, 0);

      // table: back-to-back within each configuration
      for (int i = 0; i < 10; i++) begin
         if (i > 0 && tbl[i].sel != tbl[i-1].sel) begin
            @(negedge clk);
            chk("b_done_one_cycle", done_b, 0);
         end
         run_vec(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].m, lat);
         chk($sformatf("vec%0d_latency", i), lat, 4);
         chk($sformatf("vec%0d_result", i), (tbl[i].sel == 0) ? res_b : {4'd0, res_c}, tbl[i].r);
         chk($sformatf("vec%0d_ovf", i), (tbl[i].sel == 0) ? ovf_b : ovf_c, tbl[i].o);
      end
      @(negedge clk);
      chk("c_done_one_cycle", done_c, 0);

      // start pulsed mid-RUN with other operands is ignored
      a16 = 16'h4321; b16 = 16'h8765; mode = 0; start_c = 1;
      @(posedge clk);
      @(negedge clk);
      start_c = 0;
      @(negedge clk);
      a16 = 16'hFFFF; b16 = 16'hFFFF; mode = 1; start_c = 1;
      @(negedge clk);
      start_c = 0;
      done_n = 0; r = '0; o = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (done_c) begin
            done_n++;
            if (done_n == 1) begin r = {4'd0, res_c}; o = ovf_c; end
         end
         @(negedge clk);
      end
      chk("ign_done_count", done_n, 1);
      chk("ign_result", r, 70);
      chk("ign_ovf", o, 0);

      // reset in the third RUN cycle discards the operation
      a16 = 16'hFFFF; b16 = 16'hFFFF; mode = 0; start_c = 1;
      @(posedge clk);
      @(negedge clk);
      start_c = 0;
      @(negedge clk);
      @(negedge clk);
      rst_c = 1;
      @(negedge clk);
      rst_c = 0;
      chk("mid_rst_busy", busy_c, 0);
      chk("mid_rst_done", done_c, 0);
      chk("mid_rst_result", res_c, 0);
      chk("mid_rst_ovf", ovf_c, 0);
      done_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (done_c) done_n++;
         @(negedge clk);
      end
      chk("mid_rst_no_done", done_n, 0);
      run_vec(1, 16'h1032, 16'h9714, 1'b0, lat);
      chk("post_rst_latency", lat, 4);
      chk("post_rst_result", res_c, 20);
      chk("post_rst_ovf", ovf_c, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
